// File: rtl/vga_draw_pkg.sv
// Shared encodings for the rectangle drawing engine: request modes and FSM states.
package vga_draw_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/raster_step.sv
// Raster x/y stepper: holds the current pixel and the region bounds, walks rows
// left to right and, in outline mode, skips straight to the right edge on interior rows.
module raster_step #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk_i,
    input  logic           resetn_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           outline_i,
    input  logic [X_W:0]   x_start_i,
    input  logic [X_W:0]   x_end_i,
    input  logic [Y_W:0]   y_start_i,
    input  logic [Y_W:0]   y_end_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

    logic [X_W:0] x_q, x_d, x0_q, xe_q;
    logic [Y_W:0] y_q, y_d, y0_q, ye_q;
    logic         row_end_s, edge_row_s;

    // Next pixel position: load a new origin or advance one step in raster order.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        row_end_s  = (x_q == xe_q);
        edge_row_s = (y_q == y0_q) || (y_q == ye_q);
        if (load_i) begin
            x_d = x_start_i;
            y_d = y_start_i;
        end else if (step_i) begin
            if (row_end_s) begin
                x_d = x0_q;
                y_d = y_q + Y_ONE;
            end else if (outline_i && !edge_row_s && (x_q == x0_q)) begin
                // Interior outline row: only the two edge pixels are drawn.
                x_d = xe_q;
                y_d = y_q;
            end else begin
                x_d = x_q + X_ONE;
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position and bound registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            y0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (load_i) begin
                x0_q <= x_start_i;
                y0_q <= y_start_i;
                xe_q <= x_end_i;
                ye_q <= y_end_i;
            end
        end
    end

    assign x_o    = x_q[X_W-1:0];
    assign y_o    = y_q[Y_W-1:0];
    assign last_o = row_end_s && (y_q == ye_q);

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill / outline / clear-screen pixel generator with ready backpressure.
module rect_fill
    import vga_draw_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     w,
    input  logic [Y_W-1:0]     h,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               ready,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         mode_q;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               plot_q, busy_q, done_q;
    logic [X_W:0]       rx0_s, rw_s, avail_x_s, w_eff_s, x_end_s;
    logic [Y_W:0]       ry0_s, rh_s, avail_y_s, h_eff_s, y_end_s;
    logic               region_empty_s, load_s, step_s, last_s;

    // Region selection and clipping against the screen, one bit wider than coordinates.
    always_comb begin
        if (mode == MODE_CLEAR) begin
            rx0_s   = '0;
            ry0_s   = '0;
            rw_s    = SCR_W;
            rh_s    = SCR_H;
            color_d = '0;
        end else begin
            rx0_s   = {1'b0, x0};
            ry0_s   = {1'b0, y0};
            rw_s    = {1'b0, w};
            rh_s    = {1'b0, h};
            color_d = color_in;
        end
        avail_x_s = SCR_W - rx0_s;
        avail_y_s = SCR_H - ry0_s;
        if (rw_s < avail_x_s) begin
            w_eff_s = rw_s;
        end else begin
            w_eff_s = avail_x_s;
        end
        if (rh_s < avail_y_s) begin
            h_eff_s = rh_s;
        end else begin
            h_eff_s = avail_y_s;
        end
        region_empty_s = (rx0_s >= SCR_W) || (ry0_s >= SCR_H) ||
                         (w_eff_s == '0) || (h_eff_s == '0);
        x_end_s = rx0_s + w_eff_s - X_ONE;
        y_end_s = ry0_s + h_eff_s - Y_ONE;
    end

    assign load_s = (state_q == ST_IDLE) && start;
    assign step_s = (state_q == ST_SCAN) && ready;

    // Control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = region_empty_s ? ST_DONE : ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (ready && last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request latch and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FILL;
            color_q <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_s) begin
                mode_q  <= mode;
                color_q <= color_d;
            end
            plot_q <= (state_d == ST_SCAN);
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
        end
    end

    raster_step #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_raster (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .load_i    (load_s),
        .step_i    (step_s),
        .outline_i (mode_q == MODE_OUTLINE),
        .x_start_i (rx0_s),
        .x_end_i   (x_end_s),
        .y_start_i (ry0_s),
        .y_end_i   (y_end_s),
        .x_o       (x_out),
        .y_o       (y_out),
        .last_o    (last_s)
    );

    assign color_out = color_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: fill, outline, clipping, backpressure, clear-screen and reset abort.
module tb_rect_fill;
    import vga_draw_pkg::*;

    logic       clk = 1'b0;
    logic       resetn, start, ready;
    logic [1:0] mode;
    logic [7:0] x0, w, x_out;
    logic [6:0] y0, h, y_out;
    logic [2:0] color_in, color_out;
    logic       plot, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rect_fill dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .w(w), .h(h), .color_in(color_in), .ready(ready),
        .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .plot(plot), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {plot,busy,done,x,y,color}
    function automatic logic [20:0] pack_out();
        return {plot, busy, done, x_out, y_out, color_out};
    endfunction

    task automatic expect_px(input string tag, input int ex, input int ey, input int ec);
        logic [20:0] e;
        e = {1'b1, 1'b1, 1'b0, 8'(ex), 7'(ey), 3'(ec)};
        check($sformatf("%s(%0d,%0d)", tag, ex, ey), {11'd0, pack_out()}, {11'd0, e});
        @(negedge clk);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, {29'd0, plot, busy, done}, {29'd0, 3'b011});
        @(negedge clk);
        check({tag, "_idle"}, {29'd0, plot, busy, done}, {29'd0, 3'b000});
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] ax, input logic [6:0] ay,
                         input logic [7:0] aw, input logic [6:0] ah, input logic [2:0] ac);
        mode = m; x0 = ax; y0 = ay; w = aw; h = ah; color_in = ac;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; ready = 1'b1; mode = 2'b00;
        x0 = 8'd0; y0 = 7'd0; w = 8'd0; h = 7'd0; color_in = 3'd0;
        #2;
        check("reset_state", {11'd0, pack_out()}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Fill 3x2 at (10,5)
        issue(MODE_FILL, 8'd10, 7'd5, 8'd3, 7'd2, 3'd5);
        for (int yy = 5; yy <= 6; yy++)
            for (int xx = 10; xx <= 12; xx++)
                expect_px("fill", xx, yy, 5);
        expect_done("fill");

        // Outline 4x3 at origin: row 1 only its two edges
        @(negedge clk);
        issue(MODE_OUTLINE, 8'd0, 7'd0, 8'd4, 7'd3, 3'd2);
        for (int yy = 0; yy <= 2; yy++)
            for (int xx = 0; xx <= 3; xx++)
                if (!(yy == 1 && (xx == 1 || xx == 2)))
                    expect_px("outline", xx, yy, 2);
        expect_done("outline");

        // Clipping at the bottom-right corner
        @(negedge clk);
        issue(MODE_FILL, 8'd158, 7'd119, 8'd5, 7'd5, 3'd1);
        expect_px("clip", 158, 119, 1);
        expect_px("clip", 159, 119, 1);
        expect_done("clip");

        // Zero width: done straight away, no plot
        @(negedge clk);
        issue(MODE_FILL, 8'd30, 7'd30, 8'd0, 7'd4, 3'd1);
        expect_done("w0");

        // Reserved mode behaves as fill; outline with h=1 fills the line
        @(negedge clk);
        issue(MODE_RSVD, 8'd5, 7'd5, 8'd2, 7'd1, 3'd4);
        expect_px("rsvd", 5, 5, 4);
        expect_px("rsvd", 6, 5, 4);
        expect_done("rsvd");
        @(negedge clk);
        issue(MODE_OUTLINE, 8'd40, 7'd9, 8'd3, 7'd1, 3'd6);
        for (int xx = 40; xx <= 42; xx++)
            expect_px("outl_h1", xx, 9, 6);
        expect_done("outl_h1");

        // Backpressure: first pixel held 4 cycles, stray start ignored
        @(negedge clk);
        issue(MODE_FILL, 8'd20, 7'd30, 8'd2, 7'd1, 3'd3);
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                start = 1'b1; x0 = 8'd99; y0 = 7'd99; color_in = 3'd7;
            end
            if (k == 2) start = 1'b0;
            if (k == 3) ready = 1'b1;
            expect_px("hold", 20, 30, 3);
        end
        expect_px("bp", 21, 30, 3);
        expect_done("bp");

        // Clear screen: whole screen in colour 0, region/colour inputs ignored
        @(negedge clk);
        issue(MODE_CLEAR, 8'd7, 7'd7, 8'd3, 7'd3, 3'd7);
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                expect_px("clr", xx, yy, 0);
        expect_done("clr");

        // Reset at pixel 50 of a clear: outputs drop at once, no done afterwards
        @(negedge clk);
        issue(MODE_CLEAR, 8'd1, 7'd1, 8'd1, 7'd1, 3'd5);
        for (int xx = 0; xx < 50; xx++)
            expect_px("clr2", xx, 0, 0);
        resetn = 1'b0;
        #1;
        check("async_reset", {11'd0, pack_out()}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("post_reset%0d", k), {29'd0, plot, busy, done}, 32'd0);
            @(negedge clk);
        end

        // Restart after reset
        issue(MODE_FILL, 8'd1, 7'd1, 8'd2, 7'd2, 3'd6);
        expect_px("restart", 1, 1, 6);
        expect_px("restart", 2, 1, 6);
        expect_px("restart", 1, 2, 6);
        expect_px("restart", 2, 2, 6);
        expect_done("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 160, meaning the visible columns.
REQ-002 The block SHALL have parameter SCREEN_H, default 120, meaning the visible rows.
REQ-003 The block SHALL have parameter X_W, default 8, meaning the x coordinate width.
REQ-004 The block SHALL have parameter Y_W, default 7, meaning the y coordinate width.
REQ-005 The block SHALL have parameter COLOR_W, default 3, meaning the pixel colour width.
REQ-006 The block SHALL have ports: clk in 1, the single clock; resetn in 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports: start in 1, request; mode in 2, 00 fill / 01 outline / 10 clear-screen / 11 reserved, treated as fill.
REQ-008 The block SHALL have ports: x0 in X_W; y0 in Y_W; w in X_W; h in Y_W; color_in in COLOR_W, all region and colour inputs.
REQ-009 The block SHALL have port ready in 1, indicating the downstream accepts the current pixel.
REQ-010 The block SHALL have ports: x_out out X_W; y_out out Y_W; color_out out COLOR_W; plot out 1, pixel valid.
REQ-011 The block SHALL have ports: busy out 1, and done out 1, a one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-013 In IDLE, start=1 SHALL latch mode, x0, y0, w, h and color_in, then enter SCAN; start is ignored in SCAN and DONE.
REQ-014 Clear-screen mode SHALL force region (0,0,SCREEN_W,SCREEN_H) and colour 0, ignoring the region and colour inputs.
REQ-015 Clipping at latch: effective w SHALL be min(w, SCREEN_W-x0), and effective h SHALL be min(h, SCREEN_H-y0).
REQ-016 If effective w=0, effective h=0, x0>=SCREEN_W or y0>=SCREEN_H, the block SHALL go IDLE->DONE with no plot.
REQ-017 In SCAN, plot SHALL be 1 and x_out/y_out/color_out SHALL present the current pixel, with first pixel (x0,y0) in the cycle after start.
REQ-018 A pixel SHALL advance only on a clock edge with plot=1 and ready=1; with ready=0, all outputs hold stable.
REQ-019 Scan order SHALL be raster: x increments to x0+w-1, then x wraps to x0 and y increments.
REQ-020 In outline mode, on rows strictly between y0 and y0+h-1, the step after x0 SHALL jump to x0+w-1 (w>=2), so there are no interior pixels.
REQ-021 In outline mode, w=1 or h=1 SHALL degenerate to a full fill of the line.
REQ-022 Acceptance of pixel (x0+w-1, y0+h-1) SHALL move the FSM to DONE, where done=1 and plot=0 for exactly one cycle, then IDLE.
REQ-023 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-024 Coordinate arithmetic SHALL be at X_W+1 / Y_W+1 bits internally, so no wrap-around occurs at the screen edge.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE with x_out=0, y_out=0, color_out=0, plot=0, busy=0, done=0 and the latched registers at 0.
REQ-026 Reset mid-scan SHALL abort the scan without a done pulse; the first start after release behaves as from power-up.

Structure
REQ-027 The mode encodings and state encodings SHALL live in shared package vga_draw_pkg.
REQ-028 The x/y raster stepper SHALL be a single sub-module, raster_step, holding x/y, bounds and the outline jump; the FSM and latch live in rect_fill.

Verification
REQ-029 Fill test: x0=10, y0=5, w=3, h=2, colour 5, ready=1 -> 6 plots (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) on consecutive cycles, then done on the 7th cycle.
REQ-030 Outline test: x0=0, y0=0, w=4, h=3 -> 10 plots, row 1 plots only (0,1)(3,1), then done.
REQ-031 Clip/degenerate test: x0=158, y0=119, w=5, h=5 -> plots (158,119)(159,119) then done; w=0 -> done 1 cycle after start, no plot.
REQ-032 Backpressure test: fill 2x1 with ready low for 3 cycles on the first pixel -> (x0,y0) held 4 cycles and no pixel skipped or duplicated.
REQ-033 Clear-screen/reset test: mode=10 -> 19200 plots, colour 0, last pixel (159,119); resetn low at pixel 50 -> all outputs 0 immediately and no done; a restart succeeds.
